// File: rtl/rr_grant_ctrl_if.sv
// Request/grant bundle between requesters and the round-robin grant controller.
// The master drives the requests and beat handshake; the slave returns the grant and priority pointer.
interface rr_grant_ctrl_if #(
    parameter int unsigned REQ_WIDTH = 8,
    parameter int unsigned ID_WIDTH  = 3
);
    logic [REQ_WIDTH-1:0] req;
    logic                 accept;
    logic                 last;
    logic [REQ_WIDTH-1:0] gnt;
    logic [ID_WIDTH-1:0]  gnt_id;
    logic                 gnt_valid;
    logic [REQ_WIDTH-1:0] base;

    modport master (
        output req, accept, last,
        input  gnt, gnt_id, gnt_valid, base
    );

    modport slave (
        input  req, accept, last,
        output gnt, gnt_id, gnt_valid, base
    );
endinterface

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: registers a grant from Arbiter_base, holds it for a
// transfer and rotates the priority pointer past the released requester.

// Combinational base-priority arbiter: first set req bit at or above base, wrapping.
module Arbiter_base #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    input  logic [WIDTH-1:0] base,
    output logic [WIDTH-1:0] gnt_c
);
    logic [2*WIDTH-1:0] dbl_req;
    logic [2*WIDTH-1:0] dbl_gnt;

    // Borrow from the subtraction clears every bit below the first request at/after base.
    assign dbl_req = {req, req};
    assign dbl_gnt = dbl_req & ~(dbl_req - {{WIDTH{1'b0}}, base});
    assign gnt_c   = dbl_gnt[WIDTH-1:0] | dbl_gnt[2*WIDTH-1:WIDTH];
endmodule

module rr_grant_ctrl #(
    parameter int unsigned REQ_WIDTH = 8,
    parameter int unsigned ID_WIDTH  = 3,
    parameter int unsigned MAX_HOLD  = 16,
    parameter int unsigned CNT_WIDTH = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_grant_ctrl_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
        CNT_WIDTH'((MAX_HOLD == 32'd0) ? 32'd0 : (MAX_HOLD - 32'd1));
    localparam logic [CNT_WIDTH-1:0] CNT_SAT   = '1;
    localparam logic [REQ_WIDTH-1:0] BASE_RST  = REQ_WIDTH'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [REQ_WIDTH-1:0] gnt_q, gnt_d;
    logic [ID_WIDTH-1:0]  id_q, id_d;
    logic                 valid_q, valid_d;
    logic [REQ_WIDTH-1:0] base_q, base_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [REQ_WIDTH-1:0] gnt_rot_c;
    logic [REQ_WIDTH-1:0] arb_base_c;
    logic [REQ_WIDTH-1:0] arb_gnt_c;
    logic                 hold_hit_c;
    logic                 withdrawn_c;
    logic                 release_c;

    // Binary index of a one-hot (or zero) vector.
    function automatic logic [ID_WIDTH-1:0] onehot_to_id(input logic [REQ_WIDTH-1:0] v);
        logic [ID_WIDTH-1:0] id;
        id = '0;
        for (int i = 0; i < int'(REQ_WIDTH); i++) begin
            if (v[i]) begin
                id = id | ID_WIDTH'(i);
            end
        end
        return id;
    endfunction

    // Release detection and the priority pointer used for this cycle's arbitration.
    assign gnt_rot_c   = {gnt_q[REQ_WIDTH-2:0], gnt_q[REQ_WIDTH-1]};
    assign hold_hit_c  = (MAX_HOLD != 32'd0) && bus.accept && (cnt_q == HOLD_LAST);
    assign withdrawn_c = ((bus.req & gnt_q) == '0);
    assign release_c   = (state_q == GRANT) &&
                         ((bus.accept && bus.last) || withdrawn_c || hold_hit_c);
    assign arb_base_c  = release_c ? gnt_rot_c : base_q;

    Arbiter_base #(
        .WIDTH (REQ_WIDTH)
    ) u_arb (
        .req   (bus.req),
        .base  (arb_base_c),
        .gnt_c (arb_gnt_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        valid_d = valid_q;
        base_d  = base_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.req != '0) begin
                    gnt_d   = arb_gnt_c;
                    id_d    = onehot_to_id(arb_gnt_c);
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_c) begin
                    base_d = gnt_rot_c;
                    if (arb_gnt_c != '0) begin
                        gnt_d   = arb_gnt_c;
                        id_d    = onehot_to_id(arb_gnt_c);
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        gnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else if (bus.accept && (cnt_q != CNT_SAT)) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            base_q  <= BASE_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = valid_q;
    assign bus.base      = base_q;

    // Structural invariants of the grant and pointer registers.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_base_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot(base_q));
    a_valid_match : assert property (@(posedge clk) disable iff (!rst_n) valid_q == (|gnt_q));
endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them on the cycle they fall due.
module tb_rr_grant_ctrl;
    typedef struct {
        int         due;
        string      tag;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       v;
        logic [7:0] base;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    exp_t q[$];
    exp_t mon_e;

    rr_grant_ctrl_if #(.REQ_WIDTH(8), .ID_WIDTH(3)) ifc ();

    rr_grant_ctrl #(
        .REQ_WIDTH (8),
        .ID_WIDTH  (3),
        .MAX_HOLD  (4),
        .CNT_WIDTH (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare the head expectation on the cycle it falls due.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            if (q[0].due == cyc) begin
                mon_e = q.pop_front();
                chk({mon_e.tag, ".gnt"},       32'(ifc.gnt),       32'(mon_e.gnt));
                chk({mon_e.tag, ".gnt_id"},    32'(ifc.gnt_id),    32'(mon_e.id));
                chk({mon_e.tag, ".gnt_valid"}, 32'(ifc.gnt_valid), 32'(mon_e.v));
                chk({mon_e.tag, ".base"},      32'(ifc.base),      32'(mon_e.base));
            end else if (q[0].due < cyc) begin
                mon_e = q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL %s: expectation missed, due %0d now %0d", mon_e.tag, mon_e.due, cyc);
            end
        end
    end

    // Drive one cycle of inputs and queue the state expected after the next edge.
    task automatic step(input string tag, input logic [7:0] r, input logic a, input logic l,
                        input logic [7:0] eg, input logic [2:0] eid, input logic ev,
                        input logic [7:0] eb);
        exp_t e;
        ifc.req    = r;
        ifc.accept = a;
        ifc.last   = l;
        e.due  = cyc + 1;
        e.tag  = tag;
        e.gnt  = eg;
        e.id   = eid;
        e.v    = ev;
        e.base = eb;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: %0d expectations never compared", tag, q.size());
            q.delete();
        end
    endtask

    task automatic chk_now(input string tag, input logic [7:0] eg, input logic [2:0] eid,
                           input logic ev, input logic [7:0] eb);
        chk({tag, ".gnt"},       32'(ifc.gnt),       32'(eg));
        chk({tag, ".gnt_id"},    32'(ifc.gnt_id),    32'(eid));
        chk({tag, ".gnt_valid"}, 32'(ifc.gnt_valid), 32'(ev));
        chk({tag, ".base"},      32'(ifc.base),      32'(eb));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        ifc.req    = 8'hFF;
        ifc.accept = 1'b0;
        ifc.last   = 1'b0;

        // Reset held with every requester active.
        repeat (3) @(posedge clk);
        #1;
        chk_now("rst_hold", 8'h00, 3'd0, 1'b0, 8'h01);
        rst_n = 1'b1;
        step("rst_first",   8'hFF, 1'b0, 1'b0, 8'h01, 3'd0, 1'b1, 8'h01);

        // Rotation with back-to-back re-arbitration.
        step("rot_hold",    8'h05, 1'b0, 1'b0, 8'h01, 3'd0, 1'b1, 8'h01);
        step("rot_rel1",    8'h05, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 8'h02);
        step("rot_rel2",    8'h05, 1'b1, 1'b1, 8'h01, 3'd0, 1'b1, 8'h08);
        step("rot_rel3",    8'h05, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 8'h02);

        // Withdrawal to idle; handshake ignored while idle.
        step("wdraw_idle",  8'h00, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0, 8'h08);
        step("idle_accept", 8'h00, 1'b1, 1'b1, 8'h00, 3'd2, 1'b0, 8'h08);

        // Wrap-around from base 0x80.
        step("wrap_g40",    8'h40, 1'b0, 1'b0, 8'h40, 3'd6, 1'b1, 8'h08);
        step("wrap_arm",    8'h81, 1'b0, 1'b0, 8'h80, 3'd7, 1'b1, 8'h80);
        step("wrap_rel",    8'h81, 1'b1, 1'b1, 8'h01, 3'd0, 1'b1, 8'h01);
        step("last_no_acc", 8'h81, 1'b0, 1'b1, 8'h01, 3'd0, 1'b1, 8'h01);

        // Hold limit of four accepted beats per grant.
        for (int i = 0; i < 3; i++)
            step("hold_a_r0", 8'h03, 1'b1, 1'b0, 8'h01, 3'd0, 1'b1, 8'h01);
        step("hold_lim_r0", 8'h03, 1'b1, 1'b0, 8'h02, 3'd1, 1'b1, 8'h02);
        for (int i = 0; i < 3; i++)
            step("hold_a_r1", 8'h03, 1'b1, 1'b0, 8'h02, 3'd1, 1'b1, 8'h02);
        step("hold_lim_r1", 8'h03, 1'b1, 1'b0, 8'h01, 3'd0, 1'b1, 8'h04);
        step("frozen",      8'h0D, 1'b0, 1'b0, 8'h01, 3'd0, 1'b1, 8'h04);

        // Sole requester re-wins on its own release.
        step("solo_arm",    8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b1, 8'h02);
        step("solo_rel",    8'h10, 1'b1, 1'b1, 8'h10, 3'd4, 1'b1, 8'h20);
        drain("solo");

        // Asynchronous reset mid-grant, between clock edges.
        #1;
        rst_n = 1'b0;
        #1;
        chk_now("async_rst", 8'h00, 3'd0, 1'b0, 8'h01);
        ifc.req    = 8'h00;
        ifc.accept = 1'b0;
        ifc.last   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst_idle", 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'h01);
        step("post_rst_req",  8'h02, 1'b0, 1'b0, 8'h02, 3'd1, 1'b1, 8'h01);
        drain("end");

        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
